// File: rtl/apb_master_arb_pkg.sv
// Shared types and constants for the two-host APB master.
package apb_pkg;

   localparam int unsigned ADDR_W      = 7;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned SLV_SEL_BIT = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_t;

endpackage

// File: rtl/apb_master_arb_if.sv
// APB bus bundle between the master controller and its two slaves.
interface apb_master_arb_if;
   import apb_pkg::*;

   logic              PSELECT1;
   logic              PSELECT2;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA1;
   logic [DATA_W-1:0] PRDATA2;
   logic              PREADY1;
   logic              PREADY2;
   logic              PSLVERR1;
   logic              PSLVERR2;

   modport master (
      output PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA1, PRDATA2, PREADY1, PREADY2, PSLVERR1, PSLVERR2
   );

   modport slave (
      input  PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA1, PRDATA2, PREADY1, PREADY2, PSLVERR1, PSLVERR2
   );

endinterface

// File: rtl/apb_master_arb_arb.sv
// Two-input round-robin arbiter; on a tie the host that did not win last time is granted.
module apb_rr_arb2 (
   input  logic PCLK,
   input  logic PRESET,
   input  logic req0,
   input  logic req1,
   input  logic advance,
   output logic grant
);

   logic r_last_grant;

   always_comb begin
      if (req0 && !req1)
         grant = 1'b0;
      else if (req1 && !req0)
         grant = 1'b1;
      else
         grant = ~r_last_grant;
   end

   // Resets to host 1 so host 0 wins the first tie.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET)
         r_last_grant <= 1'b1;
      else if (advance)
         r_last_grant <= grant;
   end

endmodule

// File: rtl/apb_master_arb.sv
// APB master sharing one bus between two hosts: IDLE/SETUP/ACCESS sequencing with a PREADY timeout.
module apb_master_arb
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req0,
   input  logic              wr0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   output logic              err0,
   input  logic              req1,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic              err1,
   apb_master_arb_if.master  bus
);

   apb_state_t        r_state;
   logic              r_grant;
   logic              r_sel;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_psel1, r_psel2, r_penable, r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic              r_ack0, r_ack1, r_err0, r_err1;
   logic [DATA_W-1:0] r_rdata0, r_rdata1;

   logic              w_grant, w_advance, w_ready, w_slverr, w_timeout, w_wr;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata, w_prdata;

   assign w_advance = (r_state == IDLE) && (req0 || req1);

   apb_rr_arb2 u_arb (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .req0    (req0),
      .req1    (req1),
      .advance (w_advance),
      .grant   (w_grant)
   );

   assign w_wr      = w_grant ? wr1    : wr0;
   assign w_addr    = w_grant ? addr1  : addr0;
   assign w_wdata   = w_grant ? wdata1 : wdata0;
   assign w_ready   = r_sel ? bus.PREADY2  : bus.PREADY1;
   assign w_slverr  = r_sel ? bus.PSLVERR2 : bus.PSLVERR1;
   assign w_prdata  = r_sel ? bus.PRDATA2  : bus.PRDATA1;
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         r_state   <= IDLE;
         r_grant   <= 1'b0;
         r_sel     <= 1'b0;
         r_cnt     <= '0;
         r_psel1   <= 1'b0;
         r_psel2   <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_ack0    <= 1'b0;
         r_ack1    <= 1'b0;
         r_err0    <= 1'b0;
         r_err1    <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_err0 <= 1'b0;
         r_err1 <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_advance) begin
                  r_grant  <= w_grant;
                  r_pwrite <= w_wr;
                  r_paddr  <= {1'b0, w_addr[SLV_SEL_BIT-1:0]};
                  r_pwdata <= w_wdata;
                  r_sel    <= w_addr[SLV_SEL_BIT];
                  r_psel1  <= ~w_addr[SLV_SEL_BIT];
                  r_psel2  <= w_addr[SLV_SEL_BIT];
                  r_state  <= SETUP;
               end
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ACCESS;
            end
            ACCESS: begin
               // A ready slave wins over a timeout landing in the same cycle.
               if (w_ready || w_timeout) begin
                  if (r_grant) begin
                     r_ack1 <= 1'b1;
                     r_err1 <= w_ready ? w_slverr : 1'b1;
                     if (w_ready && !r_pwrite) r_rdata1 <= w_prdata;
                  end else begin
                     r_ack0 <= 1'b1;
                     r_err0 <= w_ready ? w_slverr : 1'b1;
                     if (w_ready && !r_pwrite) r_rdata0 <= w_prdata;
                  end
                  r_psel1   <= 1'b0;
                  r_psel2   <= 1'b0;
                  r_penable <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.PSELECT1 = r_psel1;
   assign bus.PSELECT2 = r_psel2;
   assign bus.PENABLE  = r_penable;
   assign bus.PWRITE   = r_pwrite;
   assign bus.PADDR    = r_paddr;
   assign bus.PWDATA   = r_pwdata;
   assign ack0   = r_ack0;
   assign ack1   = r_ack1;
   assign err0   = r_err0;
   assign err1   = r_err1;
   assign rdata0 = r_rdata0;
   assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_apb_master_arb;
   localparam int unsigned TIMEOUT = 16;

   logic       PCLK   = 1'b0;
   logic       PRESET = 1'b0;
   logic       req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
   logic [6:0] addr0 = '0, addr1 = '0;
   logic [7:0] wdata0 = '0, wdata1 = '0;
   logic       ack0, ack1, err0, err1;
   logic [7:0] rdata0, rdata1;

   int n_total = 0;
   int n_bad   = 0;

   apb_master_arb_if bus ();

   apb_master_arb #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
      .ack0(ack0), .rdata0(rdata0), .err0(err0),
      .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
      .ack1(ack1), .rdata1(rdata1), .err1(err1),
      .bus(bus)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end
   endtask

   // Transaction-level model: who owns the bus, how many ACCESS cycles have elapsed,
   // and what each host must see when its transfer completes.
   logic       m_busy, m_setup, m_host, m_last, m_slave, m_wr;
   int unsigned m_acc;
   logic       e_psel1, e_psel2, e_pen, e_pwrite;
   logic [6:0] e_paddr;
   logic [7:0] e_pwdata;
   logic [1:0] e_ack, e_err;
   logic [7:0] e_rdata [2];

   task automatic model_step();
      logic [6:0] a;
      logic rdy, slv;
      logic [7:0] prd;
      if (!PRESET) begin
         m_busy = 0; m_setup = 0; m_host = 0; m_last = 1; m_slave = 0; m_wr = 0; m_acc = 0;
         e_pwrite = 0; e_paddr = '0; e_pwdata = '0; e_ack = '0; e_err = '0;
         e_rdata[0] = '0; e_rdata[1] = '0;
      end else begin
         e_ack = '0; e_err = '0;
         if (!m_busy) begin
            if (req0 || req1) begin
               m_host  = (req0 && req1) ? ~m_last : req1;
               m_last  = m_host;
               m_busy  = 1; m_setup = 1; m_acc = 0;
               a       = m_host ? addr1 : addr0;
               m_slave = a[6];
               m_wr    = m_host ? wr1 : wr0;
               e_pwrite = m_wr;
               e_paddr  = {1'b0, a[5:0]};
               e_pwdata = m_host ? wdata1 : wdata0;
            end
         end else if (m_setup) begin
            m_setup = 0;
         end else begin
            m_acc++;
            rdy = m_slave ? bus.PREADY2  : bus.PREADY1;
            slv = m_slave ? bus.PSLVERR2 : bus.PSLVERR1;
            prd = m_slave ? bus.PRDATA2  : bus.PRDATA1;
            if (rdy || m_acc == TIMEOUT) begin
               e_ack[m_host] = 1'b1;
               e_err[m_host] = rdy ? slv : 1'b1;
               if (rdy && !m_wr) e_rdata[m_host] = prd;
               m_busy = 0;
            end
         end
      end
      e_psel1 = m_busy && !m_slave;
      e_psel2 = m_busy && m_slave;
      e_pen   = m_busy && !m_setup;
   endtask

   initial begin
      model_step();
      forever begin
         @(posedge PCLK or negedge PRESET);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge PCLK);
         chk("m_psel1", bus.PSELECT1, e_psel1);
         chk("m_psel2", bus.PSELECT2, e_psel2);
         chk("m_penable", bus.PENABLE, e_pen);
         chk("m_ack0", ack0, e_ack[0]);
         chk("m_ack1", ack1, e_ack[1]);
         chk("m_err0", err0, e_err[0]);
         chk("m_err1", err1, e_err[1]);
         chk("m_rdata0", rdata0, e_rdata[0]);
         chk("m_rdata1", rdata1, e_rdata[1]);
         if (e_psel1 || e_psel2) begin
            chk("m_pwrite", bus.PWRITE, e_pwrite);
            chk("m_paddr", bus.PADDR, e_paddr);
            chk("m_pwdata", bus.PWDATA, e_pwdata);
         end
      end
   end

   int ord [3];
   int n_ack;
   int pen_cnt;

   initial begin
      bus.PREADY1 = 1; bus.PREADY2 = 1; bus.PSLVERR1 = 0; bus.PSLVERR2 = 0;
      bus.PRDATA1 = '0; bus.PRDATA2 = '0;
      repeat (3) @(negedge PCLK);
      #2 PRESET = 1'b1;

      // Idle after reset: everything stays zero.
      for (int i = 0; i < 10; i++) begin
         @(negedge PCLK);
         chk("idle_outs", {bus.PSELECT1, bus.PSELECT2, bus.PENABLE, bus.PWRITE, bus.PADDR,
                           bus.PWDATA, ack0, ack1, err0, err1, rdata0, rdata1}, 0);
      end

      // Host 0 write 0xA5 -> 0x05, zero-wait slave 1.
      req0 = 1; wr0 = 1; addr0 = 7'h05; wdata0 = 8'hA5;
      @(negedge PCLK);
      chk("w_setup_sel", {bus.PSELECT1, bus.PSELECT2, bus.PENABLE}, 3'b100);
      chk("w_paddr", bus.PADDR, 7'h05);
      chk("w_pwdata", bus.PWDATA, 8'hA5);
      chk("w_pwrite", bus.PWRITE, 1);
      @(negedge PCLK);
      chk("w_access", {bus.PSELECT1, bus.PENABLE, ack0}, 3'b110);
      @(negedge PCLK);
      chk("w_ack", {ack0, err0, bus.PSELECT1, bus.PENABLE}, 4'b1000);
      req0 = 0;

      // Host 0 reads it back.
      @(negedge PCLK);
      req0 = 1; wr0 = 0; bus.PRDATA1 = 8'hA5;
      repeat (3) @(negedge PCLK);
      chk("r_ack", {ack0, err0}, 2'b10);
      chk("r_rdata0", rdata0, 8'hA5);
      req0 = 0;

      // Host 1 read 0x45 from slave 2, four wait states.
      @(negedge PCLK);
      req1 = 1; wr1 = 0; addr1 = 7'h45; bus.PREADY2 = 0; bus.PRDATA2 = 8'h3C;
      for (int k = 1; k <= 7; k++) begin
         @(negedge PCLK);
         if (k == 1) begin
            chk("s2_setup", {bus.PSELECT1, bus.PSELECT2, bus.PENABLE}, 3'b010);
            chk("s2_paddr", bus.PADDR, 7'h05);
         end
         if (k >= 2 && k <= 6) chk("s2_access", {bus.PSELECT2, bus.PENABLE, ack1}, 3'b110);
         if (k == 6) bus.PREADY2 = 1;
         if (k == 7) begin
            chk("s2_ack", {ack1, err1}, 2'b10);
            chk("s2_rdata1", rdata1, 8'h3C);
            req1 = 0;
         end
      end

      // Both hosts held across three transfers.
      @(negedge PCLK);
      req0 = 1; wr0 = 1; addr0 = 7'h11; wdata0 = 8'h01;
      req1 = 1; wr1 = 1; addr1 = 7'h52; wdata1 = 8'h02;
      n_ack = 0;
      for (int k = 0; k < 30 && n_ack < 3; k++) begin
         @(negedge PCLK);
         chk("ack_excl", {ack0 & ack1}, 0);
         if (ack0 || ack1) begin
            ord[n_ack] = ack1 ? 1 : 0;
            n_ack++;
         end
      end
      req0 = 0; req1 = 0;
      chk("rr_count", n_ack, 3);
      chk("rr_order0", ord[0], 0);
      chk("rr_order1", ord[1], 1);
      chk("rr_order2", ord[2], 0);

      // Slave 1 hangs: timeout after TIMEOUT ACCESS cycles.
      @(negedge PCLK);
      bus.PREADY1 = 0; req0 = 1; wr0 = 0; addr0 = 7'h10;
      pen_cnt = 0;
      for (int k = 1; k <= 18; k++) begin
         @(negedge PCLK);
         if (bus.PENABLE) pen_cnt++;
         if (k < 18) chk("to_noack", ack0, 0);
      end
      chk("to_access_len", pen_cnt, 16);
      chk("to_ack_err", {ack0, err0}, 2'b11);
      chk("to_rdata_kept", rdata0, 8'hA5);
      req0 = 0; bus.PREADY1 = 1;
      @(negedge PCLK);
      req0 = 1; wr0 = 0; addr0 = 7'h05; bus.PRDATA1 = 8'h77;
      repeat (3) @(negedge PCLK);
      chk("after_to", {ack0, err0}, 2'b10);
      chk("after_to_rdata", rdata0, 8'h77);
      req0 = 0;

      // Slave 2 error on the completing cycle of a host 1 write.
      @(negedge PCLK);
      req1 = 1; wr1 = 1; addr1 = 7'h47; wdata1 = 8'h99;
      @(negedge PCLK);
      @(negedge PCLK);
      bus.PSLVERR2 = 1;
      @(negedge PCLK);
      chk("slverr", {ack1, err1}, 2'b11);
      bus.PSLVERR2 = 0; req1 = 0;

      // Reset in the middle of ACCESS.
      @(negedge PCLK);
      bus.PREADY1 = 0; req0 = 1; wr0 = 1; addr0 = 7'h03;
      repeat (3) @(negedge PCLK);
      chk("rst_pre_access", {bus.PSELECT1, bus.PENABLE}, 2'b11);
      #2 PRESET = 0;
      #1 chk("rst_abort", {bus.PSELECT1, bus.PENABLE, ack0}, 3'b000);
      req0 = 0;
      repeat (2) begin
         @(negedge PCLK);
         chk("rst_noack", ack0, 0);
      end
      #2 PRESET = 1;
      bus.PREADY1 = 1;

      // Random traffic; a stretch of stuck PREADY1 forces timeouts.
      for (int c = 0; c < 3000; c++) begin
         @(negedge PCLK);
         if (ack0) req0 = 0;
         else if (!req0) begin
            if ($urandom % 3 == 0) begin
               req0 = 1; wr0 = 1'($urandom); addr0 = 7'($urandom); wdata0 = 8'($urandom);
            end
         end else if ($urandom % 16 == 0) req0 = 0;
         if (ack1) req1 = 0;
         else if (!req1) begin
            if ($urandom % 3 == 0) begin
               req1 = 1; wr1 = 1'($urandom); addr1 = 7'($urandom); wdata1 = 8'($urandom);
            end
         end else if ($urandom % 16 == 0) req1 = 0;
         bus.PREADY1  = (c >= 1000 && c < 1150) ? 1'b0 : ($urandom % 3 != 0);
         bus.PREADY2  = ($urandom % 3 != 0);
         bus.PSLVERR1 = ($urandom % 8 == 0);
         bus.PSLVERR2 = ($urandom % 8 == 0);
         bus.PRDATA1  = 8'($urandom);
         bus.PRDATA2  = 8'($urandom);
      end
      req0 = 0; req1 = 0; bus.PREADY1 = 1; bus.PREADY2 = 1;
      repeat (40) @(negedge PCLK);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- APB master controller that shares one APB bus between two local requesters (host 0, host 1) and sequences IDLE/SETUP/ACCESS phases towards two 64-byte APB slaves.
- Round-robin arbitration; address bit 6 decodes slave select (PSELECT1 / PSELECT2).
- Adds a PREADY timeout, so a hung slave cannot lock the bus.
- Sits between the CPU-side request logic and the Slave1/Slave2 instances in the APB top level.

Parameters:
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY before abort (range 2..255).
- CNT_W, 8, width of timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- PCLK input 1 — bus clock; all logic on rising edge.
- PRESET input 1 — asynchronous, active-low reset.
- req0 input 1 — host 0 request; held high until ack0.
- wr0 input 1 — host 0 direction (1 = write).
- addr0 input 7 — host 0 address; [6] selects slave, [5:0] is the offset.
- wdata0 input 8 — host 0 write data.
- ack0 output 1 — one-cycle completion pulse to host 0.
- rdata0 output 8 — host 0 read data; valid when ack0 is high and wr0 = 0.
- err0 output 1 — high with ack0 on slave error or timeout.
- req1, wr1, addr1, wdata1, ack1, rdata1, err1 — same as host 0, for host 1.
- PSELECT1 output 1 — slave 1 select (addr[6] = 0).
- PSELECT2 output 1 — slave 2 select (addr[6] = 1).
- PENABLE output 1 — APB enable.
- PWRITE output 1 — APB direction.
- PADDR output 7 — APB address, driven as {1'b0, addr[5:0]}.
- PWDATA output 8 — APB write data.
- PRDATA1 input 8 — read data from slave 1.
- PRDATA2 input 8 — read data from slave 2.
- PREADY1 input 1 — ready from slave 1.
- PREADY2 input 1 — ready from slave 2.
- PSLVERR1 input 1 — error from slave 1; tied low at top level if undriven.
- PSLVERR2 input 1 — error from slave 2; tied low at top level if undriven.

Behaviour:
- Reset (PRESET = 0, asynchronous):
  - state = IDLE.
  - All outputs 0: PSELECT1/2, PENABLE, PWRITE, PADDR, PWDATA, ack*, rdata*, err*.
  - last_grant = 1, so host 0 wins the first tie.
  - Timeout counter = 0.
- All outputs are registered. Reset mid-transfer aborts immediately; no ack is issued.
- IDLE:
  - PSELx = 0, PENABLE = 0.
  - If req0 or req1 is high: choose grant (rules below), latch that host's wr/addr/wdata into PWRITE/PADDR/PWDATA, latch the slave select from addr[6], go to SETUP.
- Arbitration:
  - Only one requester high: grant it.
  - Both high: grant the host other than last_grant.
  - last_grant updates when the transfer is granted.
- SETUP (exactly 1 cycle):
  - Selected PSELx = 1, PENABLE = 0; go to ACCESS.
  - PADDR/PWRITE/PWDATA stable from SETUP through the end of ACCESS.
- ACCESS:
  - PENABLE = 1, PSELx held; counter increments each cycle.
  - PREADY from the selected slave only (PREADY1 or PREADY2, per latched select) is sampled.
  - If PREADY = 1:
    - Next cycle: ack(grant) = 1 for one cycle.
    - err(grant) = selected PSLVERR.
    - On reads, rdata(grant) = selected PRDATA, held until that host's next ack.
    - PSELx, PENABLE drop to 0; state goes to IDLE; counter clears.
  - If counter reaches TIMEOUT with PREADY still 0:
    - Same exit, with err(grant) = 1; rdata is unchanged.
- Latency and throughput:
  - Zero-wait-state slave: req sampled → SETUP (+1) → ACCESS (+2) → ack (+3).
  - Minimum 3 cycles per transfer; transfers are never overlapped.
  - IDLE always occupies at least 1 cycle between transfers.
- Host rules:
  - wr/addr/wdata are sampled only at grant.
  - Deasserting req after grant does not abort the transfer; the ack is still delivered.
  - A host must drop req in the cycle following ack, or a new transfer is arbitrated with the same fields.
  - The non-granted host's outputs are untouched.
- Error handling:
  - PSLVERR is ignored outside the completing ACCESS cycle.
  - PREADY from the unselected slave is ignored.

Decomposition:
- Shared package apb_pkg holds:
  - State encoding: IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10.
  - Constants ADDR_W = 7, DATA_W = 8, SLV_SEL_BIT = 6.
- One sub-module, apb_rr_arb2: two-input round-robin arbiter with last_grant register, inputs req0/req1/advance, output grant.
- FSM, datapath latches and timeout counter live in apb_master_arb.

Test Plan:
- Reset release with no requests:
  - All outputs stay 0 and state stays IDLE for 10 cycles.
  - Assert PRESET low mid-ACCESS → PSELx/PENABLE low immediately, no ack.
- Host 0 writes 0xA5 to addr 0x05, zero-wait slave 1:
  - PSELECT1 = 1 for 2 cycles; PENABLE high in cycle 2 only.
  - PADDR = 0x05, PWDATA = 0xA5, PWRITE = 1; ack0 pulses at +3.
  - Then host 0 reads 0x05 → rdata0 = 0xA5, err0 = 0.
- Host 1 reads addr 0x45 (slave 2), PREADY2 delayed 4 cycles:
  - PSELECT2 = 1, PADDR = 0x05; ACCESS lasts 5 cycles.
  - ack1 at +7 with rdata1 = PRDATA2.
- req0 and req1 asserted together, held across three transfers:
  - Grant order is 0, 1, 0.
  - ack0/ack1 alternate; never both high in the same cycle.
- PREADY1 stuck at 0, TIMEOUT = 16:
  - ACCESS lasts 16 cycles, then ack0 = 1, err0 = 1, rdata0 unchanged.
  - The next request completes normally.
- PSLVERR2 = 1 in the completing cycle of a host 1 write → ack1 = 1 and err1 = 1 together.
